bus_rr_sched: RTL and testbench

Single-bus round-robin scheduler for the shared packet bus. It polls the `drvrs` device FIFOs through `pndng` and grants one device at a time. It pops that device's head packet, decodes the destination field and pushes the packet to one device or to all devices on broadcast. It replaces the fixed-priority bus generator/arbiter in the same `bus_if` environment and is driven by the existing driver/monitor/checker bench.

---
 rtl/bus_rr_sched_if.sv | 38 +++
 rtl/bus_rr_sched.sv | 170 +++++++++++++++++
 tb/tb_bus_rr_sched.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_sched_if.sv
// Packet-bus interface between the round-robin scheduler and the device FIFOs.
//
// Signals:
//   pndng   FIFO i non-empty (bit i)
//   D_pop   packed FIFO heads, slice i = head of FIFO i (first-word-fall-through)
//   pop     one-hot pop strobe to the granted FIFO
//   push    push strobes to destination FIFOs
//   D_push  packet driven on the bus while any push bit is high
//
// Modports:
//   master  scheduler side (drives pop/push/D_push)
//   slave   FIFO side (drives pndng/D_pop)
interface bus_rr_sched_if #(
    parameter int unsigned drvrs   = 4,
    parameter int unsigned pckg_sz = 16
);
    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [pckg_sz-1:0]       D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

// File: rtl/bus_rr_sched.sv
// Single-bus round-robin scheduler. Grants one pending device FIFO at a time,
// pops its head packet, decodes the destination byte (top 8 bits) and pushes
// the unchanged packet to one device, or to every other device on broadcast.
// Self-addressed or out-of-range destinations are dropped and counted.
// One transfer takes four cycles: IDLE (select) -> POP -> ROUTE -> GAP.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   bus_io    packet bus (pndng/D_pop in, pop/push/D_push out)
//   grant_id  index of the device currently or last granted
//   busy      high in every state except IDLE
//   drop_cnt  saturating count of dropped packets
module bus_rr_sched #(
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_rr_sched_if.master        bus_io,
    output logic [7:0]            grant_id,
    output logic                  busy,
    output logic [15:0]           drop_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StRoute,
        StGap
    } state_e;

    localparam logic [drvrs-1:0] OneHot0 = {{(drvrs-1){1'b0}}, 1'b1};
    localparam logic [drvrs-1:0] AllOnes = '1;
    localparam logic [7:0]       LastRst = 8'(drvrs - 1);

    state_e             state_q, state_d;
    logic [7:0]         last_q, last_d;
    logic [7:0]         grant_q, grant_d;
    logic [pckg_sz-1:0] data_q, data_d;
    logic [pckg_sz-1:0] dpush_q, dpush_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic               busy_q, busy_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    // Round-robin select: lowest pending index above last, else lowest pending overall.
    logic [drvrs-1:0]   hi_mask;
    logic [drvrs-1:0]   req_hi;
    logic [7:0]         sel_lo, sel_hi, sel;
    logic [pckg_sz-1:0] sel_data;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < int'(drvrs); i++) begin
            hi_mask[i] = (i > int'(last_q));
        end
    end

    assign req_hi = bus_io.pndng & hi_mask;

    always_comb begin
        sel_lo = '0;
        sel_hi = '0;
        for (int i = int'(drvrs) - 1; i >= 0; i--) begin
            if (bus_io.pndng[i]) begin
                sel_lo = 8'(i);
            end
            if (req_hi[i]) begin
                sel_hi = 8'(i);
            end
        end
    end

    assign sel = (|req_hi) ? sel_hi : sel_lo;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(drvrs); i++) begin
            if (sel == 8'(i)) begin
                sel_data = bus_io.D_pop[i*pckg_sz +: pckg_sz];
            end
        end
    end

    logic [7:0] dest;
    assign dest = data_q[pckg_sz-1 -: 8];

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        data_d     = data_q;
        dpush_d    = dpush_q;
        pop_d      = '0;
        push_d     = '0;
        busy_d     = busy_q;
        drop_cnt_d = drop_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|bus_io.pndng) begin
                    data_d  = sel_data;
                    grant_d = sel;
                    last_d  = sel;
                    pop_d   = OneHot0 << sel;
                    busy_d  = 1'b1;
                    state_d = StPop;
                end
            end
            StPop: begin
                // Outputs are registered, so the ROUTE-cycle strobes are decided here.
                dpush_d = data_q;
                if (dest == broadcast) begin
                    push_d = AllOnes & ~(OneHot0 << grant_q);
                end else if ((32'(dest) < drvrs) && (dest != grant_q)) begin
                    push_d = OneHot0 << dest;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                state_d = StRoute;
            end
            StRoute: begin
                state_d = StGap;
            end
            StGap: begin
                // Lets the popped FIFO settle pndng before the next evaluation.
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            last_q     <= LastRst;
            grant_q    <= '0;
            data_q     <= '0;
            dpush_q    <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            dpush_q    <= dpush_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            busy_q     <= busy_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus_io.pop    = pop_q;
    assign bus_io.push   = push_q;
    assign bus_io.D_push = dpush_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Self-checking bench for bus_rr_sched: the bench plays the device FIFOs,
// a transaction-level model predicts each transfer, and a monitor checks the
// DUT's pop/route/gap cycles against the predictions.
module tb_bus_rr_sched;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   pndng_drv = '0;
    logic [N*W-1:0] dpop_drv  = '0;
    logic [7:0]     grant_id;
    logic           busy;
    logic [15:0]    drop_cnt;

    bus_rr_sched_if #(.drvrs(N), .pckg_sz(W)) bus ();
    assign bus.pndng = pndng_drv;
    assign bus.D_pop = dpop_drv;

    bus_rr_sched #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (rst),
        .bus_io   (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    typedef logic [W-1:0] pkt_q_t[$];
    pkt_q_t fifo [N];

    typedef struct {
        int           cyc;
        logic [7:0]   gnt;
        logic [N-1:0] pop;
        logic [N-1:0] push;
        logic [W-1:0] data;
        logic [15:0]  drop;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] gnt_log[$];
    int         ncmp = 0;
    int         nerr = 0;
    int         cyc = 0;
    logic       rst_seen = 1'b1;
    int         m_last = N - 1;
    int         m_next = 0;
    int         m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic void refresh();
        for (int i = 0; i < N; i++) begin
            pndng_drv[i] = (fifo[i].size() != 0);
            dpop_drv[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (fifo[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: scan devices circularly after the last grant, forward by
    // destination rules, one transfer per 4 cycles.
    function automatic void model_step();
        logic [W-1:0] pkt;
        logic [7:0]   dest;
        exp_t         e;
        int           d;
        bit           done;
        done = 1'b0;
        for (int k = 1; k <= N; k++) begin
            d = (m_last + k) % N;
            if (!done && fifo[d].size() != 0) begin
                done   = 1'b1;
                pkt    = fifo[d][0];
                dest   = pkt[W-1 -: 8];
                e.cyc  = cyc + 1;
                e.gnt  = 8'(d);
                e.pop  = '0;
                e.pop[d] = 1'b1;
                e.data = pkt;
                e.push = '0;
                if (dest == 8'hFF) begin
                    for (int i = 0; i < N; i++) e.push[i] = (i != d);
                end else if (int'(dest) < N && int'(dest) != d) begin
                    e.push[int'(dest)] = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                e.drop = 16'(m_drop);
                exp_q.push_back(e);
                m_last = d;
                m_next = cyc + 4;
            end
        end
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // FIFO side plus model evaluation, mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.pop[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        end
        refresh();
        if (rst) begin
            m_last = N - 1;
            m_next = cyc + 1;
            m_drop = 0;
            exp_q.delete();
        end else if (cyc >= m_next) begin
            model_step();
        end
    end

    // Monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pop != '0) begin
                gnt_log.push_back(grant_id);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(bus.pop), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_cycle", cyc, e.cyc);
                    chk("pop_vec", 32'(bus.pop), 32'(e.pop));
                    chk("grant_id", 32'(grant_id), 32'(e.gnt));
                    chk("busy_pop", 32'(busy), 32'd1);
                    chk("push_in_pop", 32'(bus.push), 32'd0);
                    @(posedge clk);
                    #1;
                    if (rst_seen) begin
                        chk("rst_push", 32'(bus.push), 32'd0);
                        chk("rst_pop", 32'(bus.pop), 32'd0);
                        chk("rst_busy", 32'(busy), 32'd0);
                        chk("rst_drop", 32'(drop_cnt), 32'd0);
                        chk("rst_grant", 32'(grant_id), 32'd0);
                    end else begin
                        chk("push_vec", 32'(bus.push), 32'(e.push));
                        chk("d_push", 32'(bus.D_push), 32'(e.data));
                        chk("drop_cnt", 32'(drop_cnt), 32'(e.drop));
                        chk("busy_route", 32'(busy), 32'd1);
                        chk("pop_in_route", 32'(bus.pop), 32'd0);
                        @(posedge clk);
                        #1;
                        if (!rst_seen) begin
                            chk("gap_busy", 32'(busy), 32'd1);
                            chk("gap_strobes", 32'({bus.pop, bus.push}), 32'd0);
                            @(posedge clk);
                            #1;
                            if (!rst_seen) chk("idle_busy", 32'(busy), 32'd0);
                        end
                    end
                end
            end else if (bus.push != '0) begin
                chk("spurious_push", 32'(bus.push), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic add(input int dev, input logic [W-1:0] pkt);
        fifo[dev].push_back(pkt);
        refresh();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((!all_empty() || exp_q.size() != 0 || busy !== 1'b0) && t < 3000) begin
            step();
            t++;
        end
        chk({name, "_drain"}, 32'(t < 3000), 32'd1);
        repeat (2) step();
    endtask

    task automatic wait_pop(input string name);
        int t;
        t = 0;
        while (bus.pop == '0 && t < 20) begin
            step();
            t++;
        end
        chk({name, "_pop_seen"}, 32'(bus.pop != '0), 32'd1);
    endtask

    initial begin
        // Reset state.
        @(posedge clk);
        #1;
        chk("reset_pop", 32'(bus.pop), 32'd0);
        chk("reset_push", 32'(bus.push), 32'd0);
        chk("reset_dpush", 32'(bus.D_push), 32'd0);
        chk("reset_grant", 32'(grant_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_drop", 32'(drop_cnt), 32'd0);
        #1;
        rst = 1'b0;

        // Unicast from device 2 to device 1.
        add(2, 16'h01AB);
        drain("unicast");

        // Fairness: all devices pending from one cycle, grants from device 0.
        pulse_reset();
        step();
        gnt_log.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) add(i, {8'($urandom_range(0, 3)), 8'($urandom)});
        end
        drain("fair");
        chk("fair_count", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
            chk("fair_order", 32'(gnt_log[i]), 32'(i % N));
        end

        // Broadcast.
        add(1, 16'hFF55);
        drain("bcast");

        // Drops: self-addressed, then out of range.
        pulse_reset();
        step();
        add(0, 16'h0011);
        add(0, 16'h0722);
        drain("drops");
        chk("drop_cnt_two", 32'(drop_cnt), 32'd2);

        // Random traffic with random arrival times.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                logic [7:0] dst;
                r = int'($urandom_range(0, 5));
                if (r < 4) dst = 8'($urandom_range(0, 3));
                else if (r == 4) dst = 8'hFF;
                else dst = 8'($urandom_range(4, 254));
                add(int'($urandom_range(0, N - 1)), {dst, 8'($urandom)});
            end
            step();
        end
        drain("random");

        // Reset in the pop cycle: packet lost, next grant is device 0.
        add(2, 16'h0312);
        wait_pop("midrst");
        rst = 1'b1;
        add(1, 16'h0203);
        add(0, 16'h0105);
        step();
        rst = 1'b0;
        chk("midrst_push", 32'(bus.push), 32'd0);
        chk("midrst_pop", 32'(bus.pop), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_drop", 32'(drop_cnt), 32'd0);
        chk("midrst_grant", 32'(grant_id), 32'd0);
        step();
        wait_pop("post_rst");
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        drain("post_rst");

        // Saturation: counter preloaded near the top to keep the run short.
        force dut.drop_cnt_q = 16'hFFFC;
        m_drop = 16'hFFFC;
        step();
        step();
        release dut.drop_cnt_q;
        for (int i = 0; i < 6; i++) add(1, {8'h01, 8'(i)});
        drain("sat");
        chk("sat_hold", 32'(drop_cnt), 32'hFFFF);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run did not complete, compared %0d", ncmp);
        $fatal(1, "timeout");
    end

endmodule
